mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_arb_wait_counter.sv | 17 +
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and width defaults for mem_port_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester and memory signals for mem_port_arbiter
//   master: requesters and memory (drive req/addr/wdata/mem_rdata)
//   slave : arbiter (drives done/rdata, memory strobe/address/data, busy)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_wait_counter.sv
// mem_arb_wait_counter: 4-bit load/decrement access counter; last is high when the count is zero
//   ports: clk, reset, load, dec, load_val[3:0], last
module mem_arb_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       last
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a fetch port and a data port onto one wait-state memory
//   ports: clk, reset (sync, active high), bus (mem_port_arbiter_if.slave)
//   MEM_ARB_ROUND_ROBIN_EN: simultaneous requests alternate owners instead of fixed dm priority
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_WAIT = 2
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  state_t            state;
  owner_t            owner;
  owner_t            pick;
  owner_t            gnt_own;
  logic              grant;
  logic              last;
  logic              other_req;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_owner;
  assign pick = (bus.dm_req && bus.if_req) ? (last_owner == OWN_IF ? OWN_DM : OWN_IF)
              : (bus.dm_req ? OWN_DM : OWN_IF);
  always_ff @(posedge clk)
    if (reset) last_owner <= OWN_IF;
    else if (grant) last_owner <= gnt_own;
`else
  assign pick = bus.dm_req ? OWN_DM : OWN_IF;
`endif
  // in RESP only the non-completing requester may be chained straight into ACCESS
  assign other_req = owner == OWN_IF ? bus.dm_req : bus.if_req;
  assign grant     = (state == IDLE && (bus.if_req || bus.dm_req)) || (state == RESP && other_req);
  assign gnt_own   = state == RESP ? (owner == OWN_IF ? OWN_DM : OWN_IF) : pick;
  assign gnt_we    = gnt_own == OWN_DM && bus.dm_we;
  assign gnt_addr  = gnt_own == OWN_DM ? bus.dm_addr : bus.if_addr;
  mem_arb_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .dec      (state == ACCESS && !last),
    .load_val (4'(MEM_WAIT)),
    .last     (last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_done   <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      if (grant) begin
        state         <= ACCESS;
        owner         <= gnt_own;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= gnt_we;
        bus.mem_addr  <= gnt_addr;
        bus.mem_wdata <= bus.dm_wdata;
        bus.busy      <= 1'b1;
      end else if (state == ACCESS && last) begin
        state       <= RESP;
        bus.mem_en  <= 1'b0;
        bus.mem_we  <= 1'b0;
        bus.if_done <= owner == OWN_IF;
        bus.dm_done <= owner == OWN_DM;
        if (owner == OWN_IF) bus.if_rdata <= bus.mem_rdata;
        else if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
      end else if (state == RESP) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (MEM_WAIT=2 and MEM_WAIT=0)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) z ();
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_WAIT(2)) dut (.clk(clk), .reset(reset), .bus(b));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(z));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = 0; b.dm_wdata = 0; b.mem_rdata = 0;
    z.if_req = 0; z.if_addr = 0; z.dm_req = 0; z.dm_we = 0; z.dm_addr = 0; z.dm_wdata = 0; z.mem_rdata = 0;
    tick(); tick();
    chk("rst_mem_en", b.mem_en, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", {b.if_done, b.dm_done}, 0);
    chk("rst_rdata", {b.if_rdata, b.dm_rdata}, 0);
    chk("rst_mem", {b.mem_we, b.mem_addr, b.mem_wdata}, 0);
    reset = 0;
    // single fetch
    b.if_req = 1; b.if_addr = 16'h0010; b.mem_rdata = 16'hA5A5;
    tick();
    chk("f_c1_en", b.mem_en, 1);
    chk("f_c1_addr", b.mem_addr, 16'h0010);
    chk("f_c1_we", b.mem_we, 0);
    chk("f_c1_busy", b.busy, 1);
    tick();
    chk("f_c2_en", b.mem_en, 1);
    tick();
    chk("f_c3_en", b.mem_en, 1);
    chk("f_c3_done", b.if_done, 0);
    tick();
    chk("f_c4_done", b.if_done, 1);
    chk("f_c4_rdata", b.if_rdata, 16'hA5A5);
    chk("f_c4_en", b.mem_en, 0);
    chk("f_c4_busy", b.busy, 1);
    b.if_req = 0;
    tick();
    chk("f_c5_done", b.if_done, 0);
    chk("f_c5_busy", b.busy, 0);
    // simultaneous fetch and data read: dm first
    b.if_req = 1; b.if_addr = 16'h0020; b.dm_req = 1; b.dm_we = 0; b.dm_addr = 16'h0200; b.mem_rdata = 16'h1111;
    tick();
    chk("s_c1_addr", b.mem_addr, 16'h0200);
    tick(); tick();
    tick();
    chk("s_c4_dmdone", b.dm_done, 1);
    chk("s_c4_ifdone", b.if_done, 0);
    chk("s_c4_dmrdata", b.dm_rdata, 16'h1111);
    b.dm_req = 0; b.mem_rdata = 16'h2222;
    tick();
    chk("s_c5_en", b.mem_en, 1);
    chk("s_c5_addr", b.mem_addr, 16'h0020);
    chk("s_c5_dmdone", b.dm_done, 0);
    tick(); tick();
    chk("s_c7_en", b.mem_en, 1);
    tick();
    chk("s_c8_ifdone", b.if_done, 1);
    chk("s_c8_ifrdata", b.if_rdata, 16'h2222);
    chk("s_c8_dmrdata", b.dm_rdata, 16'h1111);
    b.if_req = 0;
    tick();
    chk("s_c9_busy", b.busy, 0);
    // data write; address change mid-access ignored
    b.dm_req = 1; b.dm_we = 1; b.dm_addr = 16'h0300; b.dm_wdata = 16'h1234; b.mem_rdata = 16'hBEEF;
    tick();
    chk("w_c1_we", b.mem_we, 1);
    chk("w_c1_wdata", b.mem_wdata, 16'h1234);
    chk("w_c1_addr", b.mem_addr, 16'h0300);
    b.dm_addr = 16'h0999; b.dm_wdata = 16'hFFFF;
    tick(); tick();
    chk("w_c3_we", b.mem_we, 1);
    chk("w_c3_addr", b.mem_addr, 16'h0300);
    chk("w_c3_wdata", b.mem_wdata, 16'h1234);
    tick();
    chk("w_c4_done", b.dm_done, 1);
    chk("w_c4_rdata", b.dm_rdata, 16'h1111);
    chk("w_c4_we", b.mem_we, 0);
    b.dm_req = 0; b.dm_we = 0;
    tick();
    // reset mid-access aborts the fetch
    b.if_req = 1; b.if_addr = 16'h0040; b.mem_rdata = 16'hCCCC;
    tick(); tick();
    reset = 1;
    tick();
    chk("r_c3_en", b.mem_en, 0);
    chk("r_c3_busy", b.busy, 0);
    chk("r_c3_done", b.if_done, 0);
    chk("r_c3_rdata", b.if_rdata, 0);
    reset = 0; b.if_addr = 16'h0044; b.mem_rdata = 16'h5A5A;
    tick();
    chk("r_c4_addr", b.mem_addr, 16'h0044);
    chk("r_c4_done", b.if_done, 0);
    tick(); tick();
    chk("r_c6_done", b.if_done, 0);
    tick();
    chk("r_c7_done", b.if_done, 1);
    chk("r_c7_rdata", b.if_rdata, 16'h5A5A);
    b.if_req = 0;
    tick();
    // both requesting continuously: dm, if, dm, if back to back
    b.if_req = 1; b.if_addr = 16'h0060; b.dm_req = 1; b.dm_we = 0; b.dm_addr = 16'h0600; b.mem_rdata = 16'h0F0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a_en", b.mem_en, 1);
      chk("a_addr", b.mem_addr, (k % 2 == 0) ? 16'h0600 : 16'h0060);
      tick(); tick();
      tick();
      chk("a_done", {b.dm_done, b.if_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    b.if_req = 0; b.dm_req = 0;
    tick();
    chk("a_idle_busy", b.busy, 0);
    // MEM_WAIT=0 instance
    z.if_req = 1; z.if_addr = 16'h0050; z.mem_rdata = 16'h7777;
    tick();
    chk("z_c1_en", z.mem_en, 1);
    chk("z_c1_addr", z.mem_addr, 16'h0050);
    chk("z_c1_done", z.if_done, 0);
    z.if_req = 0;
    tick();
    chk("z_c2_en", z.mem_en, 0);
    chk("z_c2_done", z.if_done, 1);
    chk("z_c2_rdata", z.if_rdata, 16'h7777);
    tick();
    chk("z_c3_done", z.if_done, 0);
    chk("z_c3_busy", z.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
